// File: rtl/agu_pkg.sv
// Shared types and helpers for the AGU dispatch stage: op fields, size codes,
// exception codes, FSM states, alignment/byte-mask/lane-shift helpers.
package agu_pkg;

    localparam int unsigned OP_STORE_BIT = 3;
    localparam int unsigned OP_UNS_BIT   = 2;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;

    typedef enum logic [1:0] {
        IDLE,
        XLATE,
        HOLD
    } state_e;

    function automatic logic misaligned(input size_e sz, input logic [1:0] off);
        logic mis;
        case (sz)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            SZ_W:    mis = (off != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] byte_mask(input size_e sz, input logic [1:0] off);
        logic [3:0] base;
        case (sz)
            SZ_B:    base = 4'b0001;
            SZ_H:    base = 4'b0011;
            SZ_W:    base = 4'b1111;
            default: base = '0;
        endcase
        return base << off;
    endfunction

    function automatic logic [31:0] lane_shift(input logic [31:0] d, input logic [1:0] off);
        return d << {off, 3'b000};
    endfunction

endpackage

// File: rtl/agu_ibuf.sv
// Synchronous issue FIFO with flush; head entry is read combinationally.
module agu_ibuf #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             cpu_clock_i,
    input  logic             cpu_resetn_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign rdata_o = mem[rd_ptr];
    assign full_o  = (count == CNT_W'(DEPTH));
    assign empty_o = (count == '0);

    always_ff @(posedge cpu_clock_i) begin
        if (push_i && !flush_i && cpu_resetn_i) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_resetn_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) wr_ptr <= wr_ptr + 1'b1;
            if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/agu_pipe.sv
// Address-generation / dispatch stage: issue FIFO, translation handshake,
// alignment check, LQ/SQ dispatch. Optional base+imm adder under AGU_ADDR_ADD_EN.
module agu_pipe #(
    parameter int unsigned ROB_W      = 6,
    parameter int unsigned DEST_W     = 6,
    parameter int unsigned IBUF_DEPTH = 2,
    parameter int unsigned IO_BIT     = 31
) (
    input  logic              cpu_clock_i,
    input  logic              cpu_resetn_i,
    input  logic              flush_i,
    input  logic              lsu_vld_i,
    output logic              lsu_busy_o,
    input  logic [ROB_W-1:0]  lsu_rob_i,
    input  logic [3:0]        lsu_op_i,
    input  logic [31:0]       lsu_data_i,
    input  logic [31:0]       lsu_addr_i,
`ifdef AGU_ADDR_ADD_EN
    input  logic [11:0]       lsu_imm_i,
`endif
    input  logic [DEST_W-1:0] lsu_dest_i,
    output logic [31:0]       virt_addr_o,
    output logic              virt_addr_vld_o,
    output logic              isWrite_o,
    input  logic [31:0]       translated_addr_i,
    input  logic [3:0]        excp_code_i,
    input  logic              excp_code_vld_i,
    input  logic              ans_vld_i,
    input  logic              lq_full_i,
    output logic              lq_valid_o,
    output logic [31:0]       lq_addr_o,
    output logic [2:0]        lq_ld_type_o,
    output logic [DEST_W-1:0] lq_dest_o,
    output logic [ROB_W-1:0]  lq_rob_o,
    input  logic              enqueue_full_i,
    output logic              enqueue_en_o,
    output logic [29:0]       enqueue_address_o,
    output logic [31:0]       enqueue_data_o,
    output logic [3:0]        enqueue_bm_o,
    output logic              enqueue_io_o,
    output logic [ROB_W-1:0]  enqueue_rob_o,
    output logic [29:0]       conflict_address_o,
    output logic [3:0]        conflict_bm_o,
    output logic              excp_valid_o,
    output logic [31:0]       excp_addr_o,
    output logic [3:0]        excp_code_o,
    output logic [ROB_W-1:0]  excp_rob_o
);
    import agu_pkg::*;

    localparam int unsigned ENT_W = ROB_W + 4 + 32 + 32 + DEST_W;

    logic [31:0]       eff_addr;
    logic              push, pop, fifo_full, fifo_empty;
    logic [ENT_W-1:0]  head;
    logic [ROB_W-1:0]  h_rob;
    logic [3:0]        h_op;
    logic [31:0]       h_data, h_addr;
    logic [DEST_W-1:0] h_dest;
    logic              h_store, h_mis, tgt_full;
    logic [3:0]        h_bm;

    state_e            state;
    logic              xreq_q;
    logic [31:0]       paddr_q;

    logic              dispatch, fault;
    logic [3:0]        fault_code;
    logic [31:0]       disp_paddr;

`ifdef AGU_ADDR_ADD_EN
    assign eff_addr = lsu_addr_i + {{20{lsu_imm_i[11]}}, lsu_imm_i};
`else
    assign eff_addr = lsu_addr_i;
`endif

    // Busy reflects occupancy after this cycle's pop, so a full FIFO can accept while draining.
    assign lsu_busy_o = fifo_full & ~pop;
    assign push       = lsu_vld_i & ~lsu_busy_o & ~flush_i;

    agu_ibuf #(
        .DEPTH (IBUF_DEPTH),
        .WIDTH (ENT_W)
    ) u_ibuf (
        .cpu_clock_i  (cpu_clock_i),
        .cpu_resetn_i (cpu_resetn_i),
        .flush_i      (flush_i),
        .push_i       (push),
        .wdata_i      ({lsu_rob_i, lsu_op_i, lsu_data_i, eff_addr, lsu_dest_i}),
        .pop_i        (pop),
        .rdata_o      (head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    assign {h_rob, h_op, h_data, h_addr, h_dest} = head;
    assign h_store  = h_op[OP_STORE_BIT];
    assign h_mis    = misaligned(size_e'(h_op[1:0]), h_addr[1:0]);
    assign h_bm     = byte_mask(size_e'(h_op[1:0]), h_addr[1:0]);
    assign tgt_full = h_store ? enqueue_full_i : lq_full_i;

    assign virt_addr_vld_o = xreq_q & ~flush_i;

    always_comb begin
        pop        = 1'b0;
        dispatch   = 1'b0;
        fault      = 1'b0;
        fault_code = '0;
        disp_paddr = translated_addr_i;
        case (state)
            IDLE: begin
                if (!fifo_empty && h_mis) begin
                    pop        = 1'b1;
                    fault      = 1'b1;
                    fault_code = h_store ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
                end
            end
            XLATE: begin
                if (ans_vld_i) begin
                    if (excp_code_vld_i) begin
                        pop        = 1'b1;
                        fault      = 1'b1;
                        fault_code = excp_code_i;
                    end else if (!tgt_full) begin
                        pop      = 1'b1;
                        dispatch = 1'b1;
                    end
                end
            end
            HOLD: begin
                disp_paddr = paddr_q;
                if (!tgt_full) begin
                    pop      = 1'b1;
                    dispatch = 1'b1;
                end
            end
            default: ;
        endcase
        if (flush_i) begin
            pop      = 1'b0;
            dispatch = 1'b0;
            fault    = 1'b0;
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_resetn_i) begin
            state              <= IDLE;
            xreq_q             <= 1'b0;
            paddr_q            <= '0;
            virt_addr_o        <= '0;
            isWrite_o          <= 1'b0;
            lq_valid_o         <= 1'b0;
            lq_addr_o          <= '0;
            lq_ld_type_o       <= '0;
            lq_dest_o          <= '0;
            lq_rob_o           <= '0;
            enqueue_en_o       <= 1'b0;
            enqueue_address_o  <= '0;
            enqueue_data_o     <= '0;
            enqueue_bm_o       <= '0;
            enqueue_io_o       <= 1'b0;
            enqueue_rob_o      <= '0;
            conflict_address_o <= '0;
            conflict_bm_o      <= '0;
            excp_valid_o       <= 1'b0;
            excp_addr_o        <= '0;
            excp_code_o        <= '0;
            excp_rob_o         <= '0;
        end else if (flush_i) begin
            state        <= IDLE;
            xreq_q       <= 1'b0;
            lq_valid_o   <= 1'b0;
            enqueue_en_o <= 1'b0;
            excp_valid_o <= 1'b0;
        end else begin
            excp_valid_o <= fault;
            if (fault) begin
                excp_addr_o <= h_addr;
                excp_code_o <= fault_code;
                excp_rob_o  <= h_rob;
            end

            // A held valid is only kept while its own full_i blocks it; tgt_full stops overwrites.
            lq_valid_o   <= (lq_valid_o & lq_full_i) | (dispatch & ~h_store);
            enqueue_en_o <= (enqueue_en_o & enqueue_full_i) | (dispatch & h_store);

            if (dispatch && !h_store) begin
                lq_addr_o          <= disp_paddr;
                lq_ld_type_o       <= h_op[2:0];
                lq_dest_o          <= h_dest;
                lq_rob_o           <= h_rob;
                conflict_address_o <= disp_paddr[31:2];
                conflict_bm_o      <= h_bm;
            end
            if (dispatch && h_store) begin
                enqueue_address_o <= disp_paddr[31:2];
                enqueue_data_o    <= lane_shift(h_data, h_addr[1:0]);
                enqueue_bm_o      <= h_bm;
                enqueue_io_o      <= disp_paddr[IO_BIT];
                enqueue_rob_o     <= h_rob;
            end

            case (state)
                IDLE: begin
                    if (!fifo_empty && !h_mis) begin
                        state       <= XLATE;
                        xreq_q      <= 1'b1;
                        virt_addr_o <= h_addr;
                        isWrite_o   <= h_store;
                    end
                end
                XLATE: begin
                    if (ans_vld_i) begin
                        xreq_q <= 1'b0;
                        if (!excp_code_vld_i && tgt_full) begin
                            state   <= HOLD;
                            paddr_q <= translated_addr_i;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (!tgt_full) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
